// File: rtl/sbox_layer_sequencer_if.sv
// Handshake bundle for the sbox layer sequencer: state in, state out, busy.
interface sbox_layer_sequencer_if;
  logic             i_valid;
  logic             o_ready;
  logic [4:0][63:0] i_state;
  logic             o_valid;
  logic             i_ready;
  logic [4:0][63:0] o_state;
  logic             o_busy;

  // slave = the sequencer, master = whatever feeds/drains it
  modport slave  (input  i_valid, i_state, i_ready,
                  output o_ready, o_valid, o_state, o_busy);
  modport master (output i_valid, i_state, i_ready,
                  input  o_ready, o_valid, o_state, o_busy);
endinterface

// File: rtl/sbox_layer_sequencer.sv
// Ascon 5-bit substitution layer over a 320-bit state, NUM_SBOX columns per cycle.

// One Ascon sbox lookup; a[4] / y[4] carry the x0 bit.
module sbox_lane (
  input  logic [4:0] a,
  output logic [4:0] y
);
  // 32-entry Ascon sbox table
  always_comb begin
    y = 5'h00;
    case (a)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  5'h1f: y = 5'h17;
      default: y = 5'h00;
    endcase
  end
endmodule

module sbox_layer_sequencer #(
  parameter int NUM_SBOX = 8
) (
  input logic                  clock,
  input logic                  reset,
  sbox_layer_sequencer_if.slave bus
);
  localparam int NUM_STEPS = 64 / NUM_SBOX;
  localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int SH        = $clog2(NUM_SBOX);

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 &&
        NUM_SBOX != 16 && NUM_SBOX != 32 && NUM_SBOX != 64) begin : g_bad_num_sbox
      $error("sbox_layer_sequencer: NUM_SBOX must be a power of two in 1..64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      fsm, fsm_nxt;
  logic [CW-1:0]               cnt;
  logic [4:0][63:0]            st, st_sub;
  logic [5:0]                  base;
  logic                        last;
  logic [NUM_SBOX-1:0][4:0]    sin, sout;

  // First column of the active group; NUM_SBOX is a power of two so a shift suffices.
  // With NUM_SBOX=64 the whole state is one group and base is always 0.
  assign base = 6'(cnt) << SH;
  assign last = (cnt == CW'(NUM_STEPS - 1));

  // Gather the active columns into sbox inputs, x0 as MSB
  always_comb begin
    sin = '0;
    for (int l = 0; l < NUM_SBOX; l++)
      for (int b = 0; b < 5; b++)
        sin[l][4-b] = st[b][base + 6'(l)];
  end

  generate
    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
      sbox_lane u_lane (.a(sin[g]), .y(sout[g]));
    end
  endgenerate

  // Scatter sbox outputs back into the same columns; other columns pass through
  always_comb begin
    st_sub = st;
    for (int l = 0; l < NUM_SBOX; l++)
      for (int b = 0; b < 5; b++)
        st_sub[b][base + 6'(l)] = sout[l][4-b];
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // FSM next-state logic
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (bus.i_valid) fsm_nxt = RUN;
      RUN:     if (last)        fsm_nxt = DONE;
      DONE:    if (bus.i_ready) fsm_nxt = IDLE;
      default:                  fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE, so a result never overlaps the next state
  always_comb begin
    bus.o_ready = (fsm == IDLE);
    bus.o_valid = (fsm == DONE);
    bus.o_busy  = (fsm != IDLE);
  end

  assign bus.o_state = st;

  // State register and column-group counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st  <= '0;
      cnt <= '0;
    end else begin
      case (fsm)
        IDLE: if (bus.i_valid) begin
          st  <= bus.i_state;
          cnt <= '0;
        end
        RUN: begin
          st  <= st_sub;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
